// File: rtl/vga_scanout_if.sv
// rtl/vga_scanout_if.sv - SRAM read port between the scan-out engine and the SRAM arbiter
interface vga_scanout_if;
  logic        data_en;
  logic [31:0] word_address_dest;
  logic [3:0]  byte_select;
  logic [31:0] SRAM_data_in;
  logic        SRAM_busy;

  modport master (
    output data_en, word_address_dest, byte_select,
    input  SRAM_data_in, SRAM_busy
  );

  modport slave (
    input  data_en, word_address_dest, byte_select,
    output SRAM_data_in, SRAM_busy
  );
endinterface

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator with ping-pong line prefetch from SRAM
module vga_scanout #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int BPP      = 1,
  parameter bit SYNC_POL = 1'b0,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             enable,
  input  logic [31:0]      fb_base,
  vga_scanout_if.master    sram,
  output logic             h_out,
  output logic             v_out,
  output logic [BPP-1:0]   pixel_data,
  output logic             blank,
  output logic             frame_start,
  output logic             underflow,
  output logic [HW-1:0]    h_count,
  output logic [VW-1:0]    v_count,
  output logic [1:0]       h_state,
  output logic [1:0]       v_state
);

  localparam int WPL    = H_ACTIVE * BPP / 32;
  localparam int PPW    = 32 / BPP;
  localparam int PPW_LG = $clog2(PPW);
  localparam int WIW    = (WPL > 1) ? $clog2(WPL) : 1;

  localparam logic [HW-1:0] H_END_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_END_FP   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_END_SYNC = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_END_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_END_FP   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_END_SYNC = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_PRE      = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);

  typedef enum logic [1:0] {F_IDLE, F_FETCH, F_DONE} fetch_t;

  fetch_t         fstate;
  logic [WIW-1:0] widx;
  logic           back_sel;
  logic           line_ok;
  logic [31:0]    fb_q;
  logic [31:0]    lbuf [2][WPL];

  logic           h_wrap;
  logic           at_origin;
  logic           accept;
  logic           last_word;
  logic           fetch_due;
  logic [VW-1:0]  fetch_line;
  logic [31:0]    base_now;
  logic           active;
  logic [WIW-1:0] rd_idx;
  logic [31:0]    rd_word;
  logic [4:0]     pix_sh;
  logic [BPP-1:0] pix_val;

  assign h_wrap     = (h_count == H_LAST);
  assign at_origin  = (h_count == '0) && (v_count == '0);
  assign accept     = sram.data_en && !sram.SRAM_busy;
  assign last_word  = (widx == WIW'(WPL - 1));
  assign fetch_due  = (v_count < V_PRE) || (v_count == V_LAST);
  assign fetch_line = (v_count == V_LAST) ? '0 : v_count + VW'(1);
  // The line-1 fetch launches on the same cycle fb_base is sampled, so use the live value there.
  assign base_now   = at_origin ? fb_base : fb_q;

  assign active  = (h_state == 2'd0) && (v_state == 2'd0);
  assign rd_idx  = WIW'(h_count >> PPW_LG);
  assign rd_word = lbuf[~back_sel][rd_idx];
  assign pix_sh  = 5'(32'(h_count[PPW_LG-1:0]) * BPP);
  assign pix_val = BPP'(rd_word >> pix_sh);

  // Horizontal region decode from the live counter.
  always_comb begin
    h_state = 2'd3;
    if (h_count < H_END_ACT)       h_state = 2'd0;
    else if (h_count < H_END_FP)   h_state = 2'd1;
    else if (h_count < H_END_SYNC) h_state = 2'd2;
  end

  // Vertical region decode from the live counter.
  always_comb begin
    v_state = 2'd3;
    if (v_count < V_END_ACT)       v_state = 2'd0;
    else if (v_count < V_END_FP)   v_state = 2'd1;
    else if (v_count < V_END_SYNC) v_state = 2'd2;
  end

  // Pixel and line counters; disable parks them at the frame origin.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_count <= '0;
      v_count <= '0;
    end else if (!enable) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_wrap) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + VW'(1);
    end else begin
      h_count <= h_count + HW'(1);
    end
  end

  // Fetch FSM: one line ahead, bank swap and underflow detection at every line wrap.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      fstate                 <= F_IDLE;
      sram.data_en           <= 1'b0;
      sram.word_address_dest <= '0;
      sram.byte_select       <= '0;
      widx                   <= '0;
      back_sel               <= 1'b0;
      line_ok                <= 1'b0;
      underflow              <= 1'b0;
      fb_q                   <= '0;
    end else if (!enable) begin
      fstate                 <= F_IDLE;
      sram.data_en           <= 1'b0;
      sram.word_address_dest <= '0;
      sram.byte_select       <= '0;
      widx                   <= '0;
      line_ok                <= 1'b0;
    end else begin
      if (at_origin) fb_q <= fb_base;
      if (accept) begin
        widx                   <= widx + WIW'(1);
        sram.word_address_dest <= sram.word_address_dest + 32'd1;
      end
      if (h_wrap) begin
        back_sel         <= ~back_sel;
        fstate           <= F_IDLE;
        sram.data_en     <= 1'b0;
        sram.byte_select <= '0;
        widx             <= '0;
        if (fstate == F_DONE || (fstate == F_FETCH && accept && last_word)) begin
          line_ok <= 1'b1;
        end else begin
          // A line that was never fetched (or was cut short) must not be shown.
          line_ok <= 1'b0;
          if (fstate == F_FETCH) underflow <= 1'b1;
        end
      end else begin
        case (fstate)
          F_IDLE: begin
            if (h_count == '0 && fetch_due) begin
              fstate                 <= F_FETCH;
              sram.data_en           <= 1'b1;
              sram.byte_select       <= 4'b1111;
              widx                   <= '0;
              sram.word_address_dest <= base_now + 32'(fetch_line) * 32'(WPL);
            end
          end
          F_FETCH: begin
            if (accept && last_word) begin
              fstate           <= F_DONE;
              sram.data_en     <= 1'b0;
              sram.byte_select <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Line buffer storage; accepted words land in the bank not being displayed.
  always_ff @(posedge clk) begin
    if (accept) lbuf[back_sel][widx] <= sram.SRAM_data_in;
  end

  // Registered video outputs, all one cycle behind the counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      h_out       <= ~SYNC_POL;
      v_out       <= ~SYNC_POL;
      pixel_data  <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else if (!enable) begin
      h_out       <= ~SYNC_POL;
      v_out       <= ~SYNC_POL;
      pixel_data  <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_out       <= (h_state == 2'd2) ? SYNC_POL : ~SYNC_POL;
      v_out       <= (v_state == 2'd2) ? SYNC_POL : ~SYNC_POL;
      pixel_data  <= (active && line_ok) ? pix_val : '0;
      blank       <= ~active;
      frame_start <= at_origin;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - directed bench for vga_scanout: reset, timing, packing, underflow
module tb_vga_scanout;
  logic tb_clk   = 1'b0;
  logic nrst     = 1'b0;
  logic enable   = 1'b1;
  logic busy_def = 1'b1;
  int   total    = 0;
  int   bad      = 0;

  always #5 tb_clk = ~tb_clk;

  function automatic logic [31:0] mem_a(input logic [31:0] a);
    return (a == 32'd0) ? 32'h02468ACF : 32'hF000000F;
  endfunction

  vga_scanout_if sif_def ();
  vga_scanout_if sif_b1 ();
  vga_scanout_if sif_b4 ();

  assign sif_def.SRAM_busy    = busy_def;
  assign sif_def.SRAM_data_in = mem_a(sif_def.word_address_dest);
  assign sif_b1.SRAM_busy     = 1'b0;
  assign sif_b1.SRAM_data_in  = mem_a(sif_b1.word_address_dest);
  assign sif_b4.SRAM_busy     = 1'b0;
  assign sif_b4.SRAM_data_in  = (sif_b4.word_address_dest == 32'h108) ? 32'h76543210 : 32'h89ABCDEF;

  logic       ho_d, vo_d, bl_d, fs_d, uf_d;
  logic [0:0] pd_d;
  logic [9:0] hc_d, vc_d;
  logic [1:0] hs_d, vs_d;
  logic       ho_1, vo_1, bl_1, fs_1, uf_1;
  logic [0:0] pd_1;
  logic [6:0] hc_1;
  logic [2:0] vc_1;
  logic [1:0] hs_1, vs_1;
  logic       ho_4, vo_4, bl_4, fs_4, uf_4;
  logic [3:0] pd_4;
  logic [6:0] hc_4;
  logic [2:0] vc_4;
  logic [1:0] hs_4, vs_4;

  vga_scanout u_def (
    .clk(tb_clk), .nrst(nrst), .enable(enable), .fb_base(32'd0), .sram(sif_def),
    .h_out(ho_d), .v_out(vo_d), .pixel_data(pd_d), .blank(bl_d), .frame_start(fs_d),
    .underflow(uf_d), .h_count(hc_d), .v_count(vc_d), .h_state(hs_d), .v_state(vs_d)
  );

  vga_scanout #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .BPP(1)) u_b1 (
    .clk(tb_clk), .nrst(nrst), .enable(enable), .fb_base(32'd0), .sram(sif_b1),
    .h_out(ho_1), .v_out(vo_1), .pixel_data(pd_1), .blank(bl_1), .frame_start(fs_1),
    .underflow(uf_1), .h_count(hc_1), .v_count(vc_1), .h_state(hs_1), .v_state(vs_1)
  );

  vga_scanout #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
                .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .BPP(4)) u_b4 (
    .clk(tb_clk), .nrst(nrst), .enable(enable), .fb_base(32'h100), .sram(sif_b4),
    .h_out(ho_4), .v_out(vo_4), .pixel_data(pd_4), .blank(bl_4), .frame_start(fs_4),
    .underflow(uf_4), .h_count(hc_4), .v_count(vc_4), .h_state(hs_4), .v_state(vs_4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int hc(input int i);
    if (i == 0) return int'(hc_d);
    if (i == 1) return int'(hc_1);
    return int'(hc_4);
  endfunction

  function automatic int vc(input int i);
    if (i == 0) return int'(vc_d);
    if (i == 1) return int'(vc_1);
    return int'(vc_4);
  endfunction

  task automatic wait_at(input int inst, input int h, input int v, input int lim);
    int n = 0;
    while (!(hc(inst) == h && vc(inst) == v) && n < lim) begin
      @(negedge tb_clk);
      n++;
    end
    chk("wait_reached", 32'(n < lim), 32'd1);
  endtask

  int         hlow, hfirst, den, nz, blo, n, vlo;
  logic [3:0] pix [0:40];
  logic [7:0] exp8;

  initial begin
    repeat (3) @(negedge tb_clk);
    nrst = 1'b1;
    wait_at(0, 5, 0, 50);
    chk("pre_rst_den", sif_def.data_en, 1);

    // asynchronous reset in the middle of a fetch
    nrst = 1'b0;
    #1;
    chk("rst_hc", hc_d, 0);
    chk("rst_vc", vc_d, 0);
    chk("rst_den", sif_def.data_en, 0);
    chk("rst_addr", sif_def.word_address_dest, 0);
    chk("rst_bsel", sif_def.byte_select, 0);
    chk("rst_blank", bl_d, 1);
    chk("rst_hout", ho_d, 1);
    chk("rst_vout", vo_d, 1);
    chk("rst_pix", pd_d, 0);
    chk("rst_fs", fs_d, 0);
    chk("rst_uf", uf_d, 0);
    chk("rst_hstate", hs_d, 0);
    @(negedge tb_clk);
    nrst = 1'b1;
    @(negedge tb_clk);
    chk("post_rst_hc", hc_d, 1);
    chk("post_rst_den", sif_def.data_en, 1);
    chk("post_rst_addr", sif_def.word_address_dest, 20);
    chk("post_rst_bsel", sif_def.byte_select, 4'hF);

    // busy held through the whole line-1 fetch
    wait_at(0, 799, 0, 900);
    chk("stall_uf_before", uf_d, 0);
    chk("stall_addr_hold", sif_def.word_address_dest, 20);
    @(negedge tb_clk);
    chk("stall_uf_after", uf_d, 1);
    chk("stall_den_abort", sif_def.data_en, 0);
    busy_def = 1'b0;

    hlow = 0; hfirst = -1; den = 0; nz = 0;
    for (int i = 0; i < 800; i++) begin
      if (ho_d == 1'b0) begin
        if (hfirst < 0) hfirst = int'(hc_d);
        hlow++;
      end
      if (sif_def.data_en) den++;
      if (pd_d != 0) nz++;
      @(negedge tb_clk);
    end
    chk("hsync_len", hlow, 96);
    chk("hsync_first_h", hfirst, 657);
    chk("fetch_len_def", den, 20);
    chk("line1_dark", nz, 0);
    chk("period_h", hc_d, 0);
    chk("period_v", vc_d, 2);

    blo = 0;
    for (int i = 0; i < 800; i++) begin
      if (bl_d == 1'b0) blo++;
      if (hc_d == 10'd1)  pix[0] = 4'(pd_d);
      if (hc_d == 10'd5)  pix[1] = 4'(pd_d);
      if (hc_d == 10'd32) pix[2] = 4'(pd_d);
      @(negedge tb_clk);
    end
    chk("blank_len", blo, 640);
    chk("line2_px0", pix[0], 1);
    chk("line2_px4", pix[1], 0);
    chk("line2_px31", pix[2], 1);
    chk("line2_uf_sticky", uf_d, 1);

    // BPP=1 packing on line 0 of a later frame
    wait_at(1, 1, 0, 700);
    for (int i = 0; i < 36; i++) begin
      pix[i] = 4'(pd_1);
      @(negedge tb_clk);
    end
    exp8 = 8'hCF;
    for (int i = 0; i < 8; i++) chk($sformatf("b1_px%0d", i), pix[i], 32'(exp8[i]));
    chk("b1_px25", pix[25], 1);
    chk("b1_px31", pix[31], 0);
    for (int i = 32; i < 36; i++) chk($sformatf("b1_px%0d", i), pix[i], 1);
    chk("b1_uf", uf_1, 0);

    // frame period and vertical sync width
    n = 0;
    while (fs_1 !== 1'b1 && n < 1000) begin
      @(negedge tb_clk);
      n++;
    end
    chk("fs_found", fs_1, 1);
    chk("fs_at_h", hc_1, 1);
    chk("fs_at_v", vc_1, 0);
    n = 0; vlo = 0;
    do begin
      @(negedge tb_clk);
      n++;
      if (vo_1 == 1'b0) vlo++;
    end while (fs_1 !== 1'b1 && n < 1000);
    chk("frame_period", n, 640);
    chk("vsync_len", vlo, 160);

    // BPP=4: fetch length, address offset and nibble order
    wait_at(2, 1, 0, 700);
    chk("b4_addr", sif_b4.word_address_dest, 32'h108);
    den = 0;
    for (int i = 0; i < 80; i++) begin
      if (sif_b4.data_en) den++;
      @(negedge tb_clk);
    end
    chk("b4_fetch_len", den, 8);
    wait_at(2, 1, 1, 100);
    for (int i = 0; i < 9; i++) begin
      pix[i] = pd_4;
      @(negedge tb_clk);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("b4_px%0d", i), pix[i], i);
    chk("b4_px8", pix[8], 4'hF);
    chk("b4_uf", uf_4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
